// File: rtl/recv_stream.sv
// Multi-word UART receiver: packs FRAMES serial frames into one word and delivers a counted or
// continuous stream of words over valid/ready, with timeout, abort and overflow reporting.

module recv_stream_rx #(
  parameter int CLK_BAUD_RATIO = 25,
  parameter int FRAME_SIZE     = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rx_in,
  output logic [FRAME_SIZE-1:0] frame_out,
  output logic                  frame_valid_out
);

  localparam int CW = (CLK_BAUD_RATIO > 1) ? $clog2(CLK_BAUD_RATIO) : 1;
  localparam int BW = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_BAUD_RATIO - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((CLK_BAUD_RATIO > 1) ? (CLK_BAUD_RATIO / 2 - 1) : 0);
  localparam logic [BW-1:0] DATA_LAST = BW'(FRAME_SIZE - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t             rx_state_reg;
  logic                  rx_meta_reg;
  logic                  rx_sync_reg;
  logic [CW-1:0]         baud_cnt_reg;
  logic [BW-1:0]         bit_idx_reg;
  logic [FRAME_SIZE-1:0] shift_reg;

  // Start bit is re-checked half a bit in, after which every sample lands mid-bit; LSB arrives first.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      rx_state_reg    <= RX_IDLE;
      rx_meta_reg     <= 1'b1;
      rx_sync_reg     <= 1'b1;
      baud_cnt_reg    <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      frame_out       <= '0;
      frame_valid_out <= 1'b0;
    end else begin
      rx_meta_reg     <= rx_in;
      rx_sync_reg     <= rx_meta_reg;
      frame_valid_out <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          baud_cnt_reg <= '0;
          if (!rx_sync_reg) rx_state_reg <= RX_START;
        end
        RX_START: begin
          if (baud_cnt_reg == HALF_LAST) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CW'(1);
          end
        end
        RX_DATA: begin
          if (baud_cnt_reg == BIT_LAST) begin
            baud_cnt_reg <= '0;
            shift_reg    <= {rx_sync_reg, shift_reg[FRAME_SIZE-1:1]};
            if (bit_idx_reg == DATA_LAST) rx_state_reg <= RX_STOP;
            else bit_idx_reg <= bit_idx_reg + BW'(1);
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CW'(1);
          end
        end
        RX_STOP: begin
          if (baud_cnt_reg == BIT_LAST) begin
            baud_cnt_reg <= '0;
            rx_state_reg <= RX_IDLE;
            // A low stop bit is a framing error: the frame is silently dropped.
            if (rx_sync_reg) begin
              frame_out       <= shift_reg;
              frame_valid_out <= 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CW'(1);
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

endmodule

module recv_stream #(
  parameter int CLK_BAUD_RATIO = 25,
  parameter int FRAME_SIZE     = 8,
  parameter int FRAMES         = 2,
  parameter bit MSB_FIRST      = 1'b0,
  parameter int TIMEOUT_BAUDS  = 32,
  parameter int MAX_WORDS      = 256,
  localparam int DATA_SIZE     = FRAME_SIZE * FRAMES,
  localparam int WCW           = $clog2(MAX_WORDS + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rx_in,
  input  logic                 start_in,
  input  logic [WCW-1:0]       words_in,
  input  logic                 abort_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 timeout_out,
  output logic                 overflow_out
);

  localparam int FIW       = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int TO_CYCLES = TIMEOUT_BAUDS * CLK_BAUD_RATIO;
  localparam int GW        = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [FIW-1:0] LAST_IDX = FIW'(FRAMES - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'((TO_CYCLES > 0) ? (TO_CYCLES - 1) : 0);

  typedef enum logic {ST_IDLE, ST_COLLECT} state_t;

  state_t                state_reg;
  logic [FIW-1:0]        frame_idx_reg;
  logic [WCW-1:0]        words_target_reg;
  logic [WCW-1:0]        words_done_reg;
  logic [GW-1:0]         gap_cnt_reg;
  logic [DATA_SIZE-1:0]  word_buf_reg;
  logic [DATA_SIZE-1:0]  word_next;
  logic [DATA_SIZE-1:0]  data_reg;
  logic                  valid_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  timeout_reg;
  logic                  overflow_reg;
  logic [FRAME_SIZE-1:0] rx_frame;
  logic                  rx_frame_valid;

  recv_stream_rx #(
    .CLK_BAUD_RATIO(CLK_BAUD_RATIO),
    .FRAME_SIZE    (FRAME_SIZE)
  ) u_rx (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rx_in          (rx_in),
    .frame_out      (rx_frame),
    .frame_valid_out(rx_frame_valid)
  );

  // word_next is the buffer with the arriving frame dropped into the slot owned by the current index.
  generate
    for (genvar gi = 0; gi < FRAMES; gi++) begin : g_slot
      localparam int SLOT = MSB_FIRST ? (FRAMES - 1 - gi) : gi;
      assign word_next[SLOT*FRAME_SIZE +: FRAME_SIZE] =
        (rx_frame_valid && frame_idx_reg == FIW'(gi)) ? rx_frame
                                                       : word_buf_reg[SLOT*FRAME_SIZE +: FRAME_SIZE];
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_reg        <= ST_IDLE;
      frame_idx_reg    <= '0;
      words_target_reg <= '0;
      words_done_reg   <= '0;
      gap_cnt_reg      <= '0;
      word_buf_reg     <= '0;
      data_reg         <= '0;
      valid_reg        <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      timeout_reg      <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      if (valid_reg && ready_in) valid_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (start_in && !abort_in) begin
            state_reg        <= ST_COLLECT;
            busy_reg         <= 1'b1;
            words_target_reg <= words_in;
            words_done_reg   <= '0;
            overflow_reg     <= 1'b0;
            frame_idx_reg    <= '0;
            gap_cnt_reg      <= '0;
            word_buf_reg     <= '0;
          end
        end
        ST_COLLECT: begin
          if (abort_in) begin
            state_reg     <= ST_IDLE;
            busy_reg      <= 1'b0;
            frame_idx_reg <= '0;
            gap_cnt_reg   <= '0;
            word_buf_reg  <= '0;
          end else if (rx_frame_valid) begin
            gap_cnt_reg <= '0;
            if (frame_idx_reg == LAST_IDX) begin
              frame_idx_reg <= '0;
              word_buf_reg  <= '0;
              // Loading is allowed when the slot is empty or is being drained this very cycle.
              if (valid_reg && !ready_in) begin
                overflow_reg <= 1'b1;
              end else begin
                data_reg  <= word_next;
                valid_reg <= 1'b1;
              end
              if (words_done_reg != '1) words_done_reg <= words_done_reg + WCW'(1);
              if (words_target_reg != '0 && words_done_reg == words_target_reg - WCW'(1)) begin
                done_reg  <= 1'b1;
                busy_reg  <= 1'b0;
                state_reg <= ST_IDLE;
              end
            end else begin
              frame_idx_reg <= frame_idx_reg + FIW'(1);
              word_buf_reg  <= word_next;
            end
          end else if (frame_idx_reg != '0 && TO_CYCLES > 0) begin
            if (gap_cnt_reg == GAP_LAST) begin
              frame_idx_reg <= '0;
              word_buf_reg  <= '0;
              gap_cnt_reg   <= '0;
              timeout_reg   <= 1'b1;
            end else begin
              gap_cnt_reg <= gap_cnt_reg + GW'(1);
            end
          end else begin
            gap_cnt_reg <= '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign data_out     = data_reg;
  assign valid_out    = valid_reg;
  assign busy_out     = busy_reg;
  assign done_out     = done_reg;
  assign timeout_out  = timeout_reg;
  assign overflow_out = overflow_reg;

endmodule

// File: tb/tb_recv_stream.sv
// Scoreboard bench for recv_stream: LSB-first instance for most scenarios, MSB-first instance for frame order.

module tb_recv_stream;

  localparam int CBR = 25;
  localparam int WCW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic abort = 1'b0;
  logic ready0 = 1'b0;
  logic ready1 = 1'b0;
  logic [WCW-1:0] words = '0;

  logic [15:0] data0, data1;
  logic valid0, busy0, done0, to0, ovf0;
  logic valid1, busy1, done1, to1, ovf1;

  int checks = 0;
  int failures = 0;
  int done_cnt0 = 0;
  int to_cnt0 = 0;
  int done_cnt1 = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  logic [15:0] stream_words [5] = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005};

  always #5 clk = ~clk;

  recv_stream #(.MSB_FIRST(1'b0)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .rx_in(rx), .start_in(start0), .words_in(words),
    .abort_in(abort), .data_out(data0), .valid_out(valid0), .ready_in(ready0),
    .busy_out(busy0), .done_out(done0), .timeout_out(to0), .overflow_out(ovf0)
  );

  recv_stream #(.MSB_FIRST(1'b1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .rx_in(rx), .start_in(start1), .words_in(words),
    .abort_in(1'b0), .data_out(data1), .valid_out(valid1), .ready_in(ready1),
    .busy_out(busy1), .done_out(done1), .timeout_out(to1), .overflow_out(ovf1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b);
    rx = 1'b0;
    tick(CBR);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CBR);
    end
    rx = 1'b1;
    tick(2 * CBR);
  endtask

  task automatic start_dut0(input logic [WCW-1:0] w);
    words = w;
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
  endtask

  // Monitor: pops the expected word on every handshake, sampled between edges.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (valid0 && ready0) begin
        if (q0.size() == 0) check("dut0_unexpected_word", {16'h0, data0}, 32'hFFFF_FFFF);
        else check("dut0_word", {16'h0, data0}, {16'h0, q0.pop_front()});
      end
      if (valid1 && ready1) begin
        if (q1.size() == 0) check("dut1_unexpected_word", {16'h0, data1}, 32'hFFFF_FFFF);
        else check("dut1_word", {16'h0, data1}, {16'h0, q1.pop_front()});
      end
      if (done0) done_cnt0++;
      if (to0) to_cnt0++;
      if (done1) done_cnt1++;
    end
  end

  initial begin
    tick(5);
    check("rst_data", {16'h0, data0}, 32'h0);
    check("rst_valid", {31'h0, valid0}, 32'h0);
    check("rst_busy", {31'h0, busy0}, 32'h0);
    check("rst_done", {31'h0, done0}, 32'h0);
    check("rst_timeout", {31'h0, to0}, 32'h0);
    check("rst_overflow", {31'h0, ovf0}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Two counted words, LSB frame first
    ready0 = 1'b1;
    q0.push_back(16'h1234);
    q0.push_back(16'h5678);
    start_dut0(9'd2);
    check("t1_busy_after_start", {31'h0, busy0}, 32'h1);
    send_frame(8'h34); send_frame(8'h12); send_frame(8'h78); send_frame(8'h56);
    tick(10);
    check("t1_done_count", done_cnt0, 1);
    check("t1_busy_end", {31'h0, busy0}, 32'h0);
    check("t1_queue_drained", q0.size(), 0);

    // Consumer stalled: later words overflow, done still pulses
    ready0 = 1'b0;
    start_dut0(9'd3);
    send_frame(8'hB2); send_frame(8'hA1);
    tick(5);
    check("t3_valid_word0", {31'h0, valid0}, 32'h1);
    check("t3_data_word0", {16'h0, data0}, 32'hA1B2);
    check("t3_no_overflow_yet", {31'h0, ovf0}, 32'h0);
    send_frame(8'hD4); send_frame(8'hC3);
    tick(5);
    check("t3_overflow_after_word1", {31'h0, ovf0}, 32'h1);
    send_frame(8'hF6); send_frame(8'hE5);
    tick(5);
    check("t3_done_count", done_cnt0, 2);
    check("t3_busy_end", {31'h0, busy0}, 32'h0);
    check("t3_data_held", {16'h0, data0}, 32'hA1B2);
    q0.push_back(16'hA1B2);
    ready0 = 1'b1;
    tick(3);
    check("t3_valid_cleared", {31'h0, valid0}, 32'h0);

    // Inter-frame timeout discards the lone 0xAA
    q0.push_back(16'h2211);
    start_dut0(9'd1);
    check("t4_overflow_cleared", {31'h0, ovf0}, 32'h0);
    send_frame(8'hAA);
    tick(40 * CBR);
    send_frame(8'h11); send_frame(8'h22);
    tick(5);
    check("t4_timeout_count", to_cnt0, 1);
    check("t4_done_count", done_cnt0, 3);

    // Continuous mode, then abort mid-frame
    foreach (stream_words[i]) q0.push_back(stream_words[i]);
    start_dut0(9'd0);
    foreach (stream_words[i]) begin
      send_frame(stream_words[i][7:0]);
      send_frame(stream_words[i][15:8]);
    end
    tick(5);
    check("t5_busy_streaming", {31'h0, busy0}, 32'h1);
    fork
      send_frame(8'h5A);
      begin
        tick(4 * CBR);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
      end
    join
    tick(5);
    check("t5_busy_after_abort", {31'h0, busy0}, 32'h0);
    check("t5_no_done", done_cnt0, 3);
    check("t5_queue_drained", q0.size(), 0);

    // Reset in the middle of a word
    start_dut0(9'd1);
    send_frame(8'h99);
    tick(3);
    rst_n = 1'b0;
    tick(2);
    check("t6_rst_data", {16'h0, data0}, 32'h0);
    check("t6_rst_valid", {31'h0, valid0}, 32'h0);
    check("t6_rst_busy", {31'h0, busy0}, 32'h0);
    check("t6_rst_overflow", {31'h0, ovf0}, 32'h0);
    rst_n = 1'b1;
    tick(2);
    q0.push_back(16'h0201);
    start_dut0(9'd1);
    send_frame(8'h01); send_frame(8'h02);
    tick(5);
    check("t6_done_count", done_cnt0, 4);
    check("t6_queue_drained", q0.size(), 0);

    // MSB-first instance, consumer waits
    q1.push_back(16'h1234);
    words = 9'd1;
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    check("t2_busy_after_start", {31'h0, busy1}, 32'h1);
    send_frame(8'h12); send_frame(8'h34);
    tick(5);
    check("t2_valid_held", {31'h0, valid1}, 32'h1);
    check("t2_data", {16'h0, data1}, 32'h1234);
    check("t2_busy_end", {31'h0, busy1}, 32'h0);
    check("t2_done_count", done_cnt1, 1);
    ready1 = 1'b1;
    tick(3);
    check("t2_valid_cleared", {31'h0, valid1}, 32'h0);
    check("t2_queue_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
